// File: rtl/bus_trace_pkg.sv
// rtl/bus_trace_pkg.sv - shared types for the bus trace capture block
package bus_trace_pkg;

  // Capture run phases, encoded as seen on the state output
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - trace storage, one synchronous write port, one asynchronous read port
module trace_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 26,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are never reset; the pointers and count decide what is valid
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bus_trace.sv
// rtl/bus_trace.sv - circular bus-cycle trace with address trigger and oldest-first drain
module bus_trace
  import bus_trace_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int DEPTH = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1,
  localparam int ENTRY_W = ADDR_W + DATA_W + 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               arm,
  input  logic               abort,
  input  logic               sample_en,
  input  logic [ADDR_W-1:0]  bus_address,
  input  logic [DATA_W-1:0]  bus_wr_data,
  input  logic [DATA_W-1:0]  bus_rd_data,
  input  logic               bus_wr_enable,
  input  logic [ADDR_W-1:0]  trig_addr,
  input  logic [ADDR_W-1:0]  trig_mask,
  input  logic [CNT_W-1:0]   post_count,
  input  logic               rd_ready,
  output logic               rd_valid,
  output logic [ENTRY_W-1:0] rd_entry,
  output logic [CNT_W-1:0]   count,
  output logic [1:0]         state,
  output logic               triggered,
  output logic               overflow
);

  state_t             st;
  logic [PTR_W-1:0]   wptr, rptr, wptr_nxt;
  logic [CNT_W-1:0]   postcnt, count_nxt, post_clamp;
  logic               capturing, match, trig_hit, full, rearm, pop;
  logic [DATA_W-1:0]  data_sel;
  logic [ENTRY_W-1:0] wr_entry, ram_rdata;

  // Capture qualification, trigger compare and next-pointer values used when entering DONE
  always_comb begin
    capturing  = ((st == ST_ARMED) || (st == ST_CAPTURE)) && sample_en;
    match      = sample_en && (((bus_address ^ trig_addr) & trig_mask) == '0);
    trig_hit   = (st == ST_ARMED) && match;
    full       = (count == CNT_W'(DEPTH));
    data_sel   = bus_wr_enable ? bus_wr_data : bus_rd_data;
    wr_entry   = {trig_hit, bus_wr_enable, bus_address, data_sel};
    rearm      = arm && !abort && ((st == ST_IDLE) || (st == ST_DONE));
    pop        = rd_valid && rd_ready && !rearm;
    wptr_nxt   = capturing ? wptr + 1'b1 : wptr;
    count_nxt  = (capturing && !full) ? count + 1'b1 : count;
    // Clamping keeps the trigger entry from being overwritten by its own post window
    post_clamp = (post_count > CNT_W'(DEPTH - 1)) ? CNT_W'(DEPTH - 1) : post_count;
  end

  // Run-control FSM together with buffer pointers, occupancy and status flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st        <= ST_IDLE;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      postcnt   <= '0;
      triggered <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (capturing) begin
        wptr <= wptr_nxt;
        count <= count_nxt;
        if (full) overflow <= 1'b1;
      end
      case (st)
        ST_IDLE, ST_DONE: begin
          if (rearm) begin
            st        <= ST_ARMED;
            wptr      <= '0;
            count     <= '0;
            triggered <= 1'b0;
            overflow  <= 1'b0;
          end else if (pop) begin
            rptr  <= rptr + 1'b1;
            count <= count - 1'b1;
          end
        end
        ST_ARMED: begin
          if (trig_hit) begin
            triggered <= 1'b1;
            postcnt   <= post_clamp;
          end
          if (abort || (trig_hit && post_clamp == '0)) begin
            st   <= ST_DONE;
            rptr <= wptr_nxt - count_nxt[PTR_W-1:0];
          end else if (trig_hit) begin
            st <= ST_CAPTURE;
          end
        end
        default: begin
          if (capturing) postcnt <= postcnt - 1'b1;
          if (abort || (capturing && postcnt == CNT_W'(1))) begin
            st   <= ST_DONE;
            rptr <= wptr_nxt - count_nxt[PTR_W-1:0];
          end
        end
      endcase
    end
  end

  trace_ram #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_ram (
    .clk   (clk),
    .we    (capturing),
    .waddr (wptr),
    .wdata (wr_entry),
    .raddr (rptr),
    .rdata (ram_rdata)
  );

  assign rd_valid = (count != '0) && (st == ST_DONE);
  assign rd_entry = rd_valid ? ram_rdata : '0;
  assign state    = st;

endmodule

// File: tb/tb_bus_trace.sv
// tb/tb_bus_trace.sv - randomized and directed bench for bus_trace against a queue model
module tb_bus_trace;

  localparam int DEPTH = 64;
  localparam int S_IDLE = 0, S_ARMED = 1, S_CAPTURE = 2, S_DONE = 3;

  logic        clk = 1'b0, resetn = 1'b0, arm = 1'b0, abort = 1'b0, sample_en = 1'b0;
  logic        bus_wr_enable = 1'b0, rd_ready = 1'b0;
  logic [15:0] bus_address = '0, trig_addr = '0, trig_mask = '0;
  logic [7:0]  bus_wr_data = '0, bus_rd_data = '0;
  logic [6:0]  post_count = '0;
  logic        rd_valid, triggered, overflow;
  logic [25:0] rd_entry;
  logic [6:0]  count;
  logic [1:0]  state;

  bus_trace dut (
    .clk(clk), .resetn(resetn), .arm(arm), .abort(abort), .sample_en(sample_en),
    .bus_address(bus_address), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
    .bus_wr_enable(bus_wr_enable), .trig_addr(trig_addr), .trig_mask(trig_mask),
    .post_count(post_count), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_entry(rd_entry),
    .count(count), .state(state), .triggered(triggered), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  logic [25:0] q[$];
  logic [25:0] drained[$];
  int   mstate = S_IDLE, remaining = 0;
  logic mtrig = 1'b0, movf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete(); mstate = S_IDLE; mtrig = 1'b0; movf = 1'b0; remaining = 0;
  endtask

  // One clock: check read port, advance the model from the spec rules, check registered outputs
  task automatic cycle();
    logic exp_v, cap, hit, rearm;
    #2;
    exp_v = (mstate == S_DONE) && (q.size() != 0);
    check("rd_valid", rd_valid, exp_v);
    if (exp_v) check("rd_entry", rd_entry, q[0]);
    else check("rd_entry_zero", rd_entry, 0);
    rearm = arm && !abort && (mstate == S_IDLE || mstate == S_DONE);
    if (exp_v && rd_ready && !rearm) drained.push_back(rd_entry);
    @(posedge clk);
    cap = (mstate == S_ARMED || mstate == S_CAPTURE) && sample_en;
    hit = (mstate == S_ARMED) && sample_en && (((bus_address ^ trig_addr) & trig_mask) == 0);
    if (cap) begin
      q.push_back({hit, bus_wr_enable, bus_address, bus_wr_enable ? bus_wr_data : bus_rd_data});
      if (q.size() > DEPTH) begin void'(q.pop_front()); movf = 1'b1; end
    end
    case (mstate)
      S_ARMED: begin
        if (hit) begin mtrig = 1'b1; remaining = (post_count > DEPTH - 1) ? DEPTH - 1 : int'(post_count); end
        if (abort || (hit && remaining == 0)) mstate = S_DONE;
        else if (hit) mstate = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (cap) remaining--;
        if (abort || (cap && remaining == 0)) mstate = S_DONE;
      end
      default: begin
        if (rearm) begin q.delete(); mtrig = 1'b0; movf = 1'b0; mstate = S_ARMED; end
        else if (exp_v && rd_ready) void'(q.pop_front());
      end
    endcase
    #1;
    check("state", 32'(state), mstate);
    check("count", 32'(count), q.size());
    check("triggered", 32'(triggered), 32'(mtrig));
    check("overflow", 32'(overflow), 32'(movf));
  endtask

  task automatic do_arm(input logic [15:0] ta, input logic [15:0] tm, input logic [6:0] pc);
    trig_addr = ta; trig_mask = tm; post_count = pc;
    sample_en = 1'b0; arm = 1'b1; cycle(); arm = 1'b0;
    drained.delete();
  endtask

  task automatic samp(input logic [15:0] a, input logic we, input logic [7:0] wd, input logic [7:0] rd);
    bus_address = a; bus_wr_enable = we; bus_wr_data = wd; bus_rd_data = rd;
    sample_en = 1'b1; cycle(); sample_en = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1; cycle(); abort = 1'b0;
  endtask

  // mode 0: always ready, 1: toggling, 2: random
  task automatic drain(input int mode);
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((n % 2) == 0) : 1'(($urandom % 3) != 0);
      cycle(); n++;
    end
    rd_ready = 1'b0;
    check("drain_bound", 32'(q.size()), 0);
  endtask

  initial begin
    // Reset values
    resetn = 1'b0; model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(state), S_IDLE);
    check("rst_count", 32'(count), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_entry", 32'(rd_entry), 0);
    check("rst_trig", 32'(triggered), 0);
    check("rst_ovf", 32'(overflow), 0);
    resetn = 1'b1;

    // Reset asserted in the middle of CAPTURE
    do_arm(16'h0, 16'h0, 7'd50);
    for (int i = 0; i < 5; i++) samp(16'h0100 + 16'(i), 1'b0, 8'h00, 8'(i));
    check("t1_in_capture", 32'(state), S_CAPTURE);
    resetn = 1'b0; #1;
    check("t1_state", 32'(state), S_IDLE);
    check("t1_count", 32'(count), 0);
    check("t1_trig", 32'(triggered), 0);
    check("t1_rd_valid", 32'(rd_valid), 0);
    model_reset();
    @(posedge clk); #1;
    resetn = 1'b1;
    check("t1_rd_valid_next", 32'(rd_valid), 0);
    check("t1_state_next", 32'(state), S_IDLE);

    // Exact trigger with a two-entry post window
    do_arm(16'h0205, 16'hFFFF, 7'd2);
    for (int i = 0; i < 10; i++) samp(16'h0200 + 16'(i), 1'b0, 8'h00, 8'(i));
    check("t2_count", 32'(count), 8);
    check("t2_ovf", 32'(overflow), 0);
    drain(0);
    check("t2_ndrained", drained.size(), 8);
    for (int i = 0; i < drained.size(); i++) begin
      check("t2_addr", 32'(drained[i][23:8]), 32'h0200 + i);
      check("t2_trig", 32'(drained[i][25]), (i == 5) ? 1 : 0);
    end

    // No trigger, overflow and abort
    do_arm(16'hFFFF, 16'hFFFF, 7'd3);
    for (int i = 0; i < 100; i++) samp(16'h1000 + 16'(i), 1'b0, 8'h00, 8'(i));
    do_abort();
    check("t3_count", 32'(count), 64);
    check("t3_ovf", 32'(overflow), 1);
    drain(0);
    check("t3_first", 32'(drained[0][23:8]), 32'h1000 + 36);
    check("t3_last", 32'(drained[drained.size()-1][23:8]), 32'h1000 + 99);

    // Match-any with zero post window, then an over-large window clamped to DEPTH-1
    do_arm(16'h1234, 16'h0000, 7'd0);
    samp(16'h4000, 1'b0, 8'h00, 8'h11);
    check("t4_done", 32'(state), S_DONE);
    check("t4_count", 32'(count), 1);
    drain(0);
    check("t4_trigbit", 32'(drained[0][25]), 1);
    do_arm(16'h1234, 16'h0000, 7'd127);
    for (int i = 0; i < 63; i++) samp(16'h5000 + 16'(i), 1'b0, 8'h00, 8'(i));
    check("t4_still_capture", 32'(state), S_CAPTURE);
    samp(16'h503F, 1'b0, 8'h00, 8'h3F);
    samp(16'h5040, 1'b0, 8'h00, 8'h40);
    check("t4_clamp_count", 32'(count), 64);
    check("t4_clamp_ovf", 32'(overflow), 0);
    drain(2);
    check("t4_clamp_trig", 32'(drained[0][25]), 1);

    // Data field selection on write and read cycles
    do_arm(16'hFFFF, 16'hFFFF, 7'd0);
    samp(16'h0300, 1'b1, 8'hA5, 8'h3C);
    samp(16'h0301, 1'b0, 8'hA5, 8'h3C);
    do_abort();
    drain(0);
    check("t5_wr_data", 32'(drained[0][7:0]), 32'hA5);
    check("t5_wr_we", 32'(drained[0][24]), 1);
    check("t5_rd_data", 32'(drained[1][7:0]), 32'h3C);
    check("t5_rd_we", 32'(drained[1][24]), 0);

    // abort together with arm in CAPTURE, then a toggling-ready drain
    do_arm(16'h0, 16'h0, 7'd10);
    for (int i = 0; i < 3; i++) samp(16'h0600 + 16'(i), 1'b0, 8'h00, 8'(i));
    bus_address = 16'h0603; sample_en = 1'b1; abort = 1'b1; arm = 1'b1;
    cycle();
    abort = 1'b0; arm = 1'b0; sample_en = 1'b0;
    check("t6_state", 32'(state), S_DONE);
    check("t6_count", 32'(count), 4);
    drain(1);
    check("t6_ndrained", drained.size(), 4);
    for (int i = 0; i < drained.size(); i++) check("t6_order", 32'(drained[i][23:8]), 32'h0600 + i);

    // Randomized runs
    for (int r = 0; r < 12; r++) begin
      int n = 0;
      do_arm(16'($urandom), 16'($urandom) & ((r % 3 == 0) ? 16'h00FF : 16'h000F), 7'($urandom));
      while (mstate != S_DONE && n < 400) begin
        bus_address = 16'($urandom); bus_wr_enable = 1'($urandom);
        bus_wr_data = 8'($urandom); bus_rd_data = 8'($urandom);
        sample_en = 1'(($urandom % 4) != 0);
        abort = 1'(($urandom % 150) == 0);
        arm = 1'(($urandom % 40) == 0);
        rd_ready = 1'($urandom);
        cycle(); n++;
      end
      abort = 1'b0; arm = 1'b0;
      if (mstate != S_DONE) do_abort();
      sample_en = 1'($urandom);
      drain(2);
      sample_en = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
